// File: rtl/audioport_irq_gen.sv
// Audioport interrupt generator: counts consumed samples and raises irq_out once per block.
// Optional overrun flag enabled by defining AUDIOPORT_IRQ_OVERRUN_EN.
module audioport_irq_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic             tick_in,
  input  logic [CNT_W-1:0] irq_period_in,
  input  logic             irq_ack_in,
  output logic             irq_out,
  output logic             play_out,
  output logic             overrun_out,
  output logic [CNT_W-1:0] tick_count_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] cnt_r;
  logic             irq_r;
  logic             running;
  logic             start_ok;
  logic             expiry;

  assign running  = (state_r == RUN) || (state_r == PEND);
  assign start_ok = start_in && (irq_period_in != '0);
  // cnt_r <= 1 rather than == 1 so a corrupted zero count can never wrap
  assign expiry   = running && tick_in && (cnt_r <= CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      period_r <= '0;
      cnt_r    <= '0;
      irq_r    <= 1'b0;
    end else if (stop_in) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else if (start_ok) begin
      state_r  <= RUN;
      period_r <= irq_period_in;
      cnt_r    <= irq_period_in;
      irq_r    <= 1'b0;
    end else if (expiry) begin
      cnt_r   <= period_r;
      irq_r   <= 1'b1;
      state_r <= PEND;
    end else begin
      if (running && tick_in) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
      if (irq_ack_in && irq_r) begin
        irq_r <= 1'b0;
        if (state_r == PEND) begin
          state_r <= RUN;
        end
      end
    end
  end

`ifdef AUDIOPORT_IRQ_OVERRUN_EN
  logic ovr_r;

  // An ack arriving with the expiring tick services the old request, so no overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_r <= 1'b0;
    end else if (stop_in) begin
      ovr_r <= ovr_r;
    end else if (start_ok) begin
      ovr_r <= 1'b0;
    end else if (expiry && (state_r == PEND) && !irq_ack_in) begin
      ovr_r <= 1'b1;
    end
  end

  assign overrun_out = ovr_r;
`else
  assign overrun_out = 1'b0;
`endif

  assign irq_out        = irq_r;
  assign play_out       = running;
  assign tick_count_out = cnt_r;

endmodule

// File: tb/tb_audioport_irq_gen.sv
// Scoreboard testbench for audioport_irq_gen: a behavioural model pushes expected
// outputs per driven cycle, which are popped and compared one cycle later.
module tb_audioport_irq_gen;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic             irq;
    logic             play;
    logic             ovr;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_in = 1'b0;
  logic             stop_in = 1'b0;
  logic             tick_in = 1'b0;
  logic [CNT_W-1:0] irq_period_in = '0;
  logic             irq_ack_in = 1'b0;
  logic             irq_out;
  logic             play_out;
  logic             overrun_out;
  logic [CNT_W-1:0] tick_count_out;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Model state: pending request is simply play && irq
  logic             m_play = 1'b0;
  logic             m_irq = 1'b0;
  logic             m_ovr = 1'b0;
  logic [CNT_W-1:0] m_period = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  audioport_irq_gen #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start_in),
    .stop_in        (stop_in),
    .tick_in        (tick_in),
    .irq_period_in  (irq_period_in),
    .irq_ack_in     (irq_ack_in),
    .irq_out        (irq_out),
    .play_out       (play_out),
    .overrun_out    (overrun_out),
    .tick_count_out (tick_count_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic st, input logic sp, input logic tk,
                           input logic [CNT_W-1:0] per, input logic ak);
    if (r) begin
      m_play = 1'b0; m_irq = 1'b0; m_ovr = 1'b0; m_period = '0; m_cnt = '0;
    end else if (sp) begin
      m_play = 1'b0;
      m_cnt  = '0;
    end else if (st && per != 0) begin
      m_play = 1'b1; m_period = per; m_cnt = per; m_irq = 1'b0; m_ovr = 1'b0;
    end else if (m_play && tk && m_cnt == 1) begin
      if (m_irq && !ak) m_ovr = 1'b1;
      m_irq = 1'b1;
      m_cnt = m_period;
    end else begin
      if (m_play && tk) m_cnt = m_cnt - 1'b1;
      if (ak) m_irq = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic sp, input logic tk,
                               input logic [CNT_W-1:0] per, input logic ak);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; start_in = st; stop_in = sp; tick_in = tk; irq_period_in = per; irq_ack_in = ak;
    modelStep(r, st, sp, tk, per, ak);
    e.irq  = m_irq;
    e.play = m_play;
`ifdef AUDIOPORT_IRQ_OVERRUN_EN
    e.ovr  = m_ovr;
`else
    e.ovr  = 1'b0;
`endif
    e.cnt  = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0; start_in = 1'b0; stop_in = 1'b0; tick_in = 1'b0; irq_ack_in = 1'b0;
    got = exp_q.pop_front();
    checkOutput("irq_out", 32'(irq_out), 32'(got.irq));
    checkOutput("play_out", 32'(play_out), 32'(got.play));
    checkOutput("overrun_out", 32'(overrun_out), 32'(got.ovr));
    checkOutput("tick_count_out", 32'(tick_count_out), 32'(got.cnt));
  endtask

  initial begin
    // Reset
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 5, 1);

    // Period 4, four back-to-back ticks, then ack and another block
    applyStimulus(0, 1, 0, 0, 4, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Period 2, no ack: overrun on second expiry
    applyStimulus(0, 1, 0, 0, 2, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 0);

    // Period 3: ack coincides with expiry while pending
    applyStimulus(0, 1, 0, 0, 3, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Start and stop together while running, then zero-period start from IDLE
    applyStimulus(0, 1, 1, 0, 5, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // Period 1: every tick expires
    applyStimulus(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0);

    // Largest period decrements from all-ones
    applyStimulus(0, 1, 0, 0, 16'hFFFF, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // Reset mid-block with irq and overrun set, then ticks ignored
    applyStimulus(0, 1, 0, 0, 2, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // Random mix
    for (int i = 0; i < 200; i++) begin
      logic st, sp, tk, ak;
      logic [CNT_W-1:0] per;
      st  = ($urandom_range(0, 15) == 0);
      sp  = ($urandom_range(0, 31) == 0);
      tk  = ($urandom_range(0, 2) != 0);
      ak  = ($urandom_range(0, 5) == 0);
      per = CNT_W'($urandom_range(0, 4));
      applyStimulus(0, st, sp, tk, per, ak);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/audioport_irq_gen.md
# audioport_irq_gen

Interrupt generator that produces the audioport `irq_out` request consumed by the CPU-side `irq_out` interface. Counts samples consumed by the audio output stage and raises an interrupt once per programmed block of samples, so software can refill the sample buffer. Holds the request until software acknowledges it, and flags overrun when a block expires while a request is still pending.

## Interface
- `CNT_W`, default 16: width of the block-length register and sample counter.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start_in`  in  1  one-cycle pulse: start or restart playback.
- `stop_in`  in  1  one-cycle pulse: stop playback.
- `tick_in`  in  1  one-cycle strobe per sample consumed by the output stage.
- `irq_period_in`  in  CNT_W  samples per interrupt; sampled only on an accepted `start_in`.
- `irq_ack_in`  in  1  one-cycle pulse from the CPU register write clearing the request.
- `irq_out`  out  1  interrupt request, level, registered.
- `play_out`  out  1  high while the FSM is in RUN or PEND.
- `overrun_out`  out  1  sticky: a block expired while `irq_out` was already high.
- `tick_count_out`  out  CNT_W  remaining samples in the current block.

## Operation
- Registers: `period_r` (CNT_W), `cnt_r` (CNT_W), FSM state, `irq_r`, `ovr_r`.
- FSM states:
  - IDLE: no counting.
  - RUN: counting, no request pending.
  - PEND: counting, request pending.
- Start:
  - `start_in` with `irq_period_in != 0`: `period_r <= irq_period_in`, `cnt_r <= irq_period_in`, `irq_r <= 0`, `ovr_r <= 0`, state to RUN. Accepted from any state; restarts when already running.
  - `start_in` with `irq_period_in == 0`: ignored, no state change.
- Stop: `stop_in` moves state to IDLE and sets `cnt_r <= 0`. `irq_r` and `ovr_r` are kept until ack or restart.
- Counting:
  - `tick_in` in RUN/PEND with `cnt_r > 1`: `cnt_r` decrements.
  - `tick_in` with `cnt_r == 1` (block expiry): `cnt_r <= period_r` and `irq_r <= 1`. RUN goes to PEND. In PEND, expiry also sets `ovr_r`.
  - `tick_in` in IDLE: ignored.
- Ack: `irq_ack_in` clears `irq_r`. PEND goes to RUN. In IDLE the ack only clears `irq_r`.
- Priority, highest first: `rst` > `stop_in` > `start_in` > expiry > `irq_ack_in`.
- Simultaneous events:
  - start and stop in the same cycle: stop wins.
  - expiry and ack in PEND: `irq_r` stays 1, `ovr_r` is **not** set (the old request was serviced), state stays PEND.
  - ack with no pending request: no effect.
- Arithmetic: unsigned; `cnt_r` never wraps below 1 while running.

## Timing
- All outputs registered. Reset value of every output is 0, state IDLE, `period_r = 0`.
- `irq_out` rises the cycle after the clock edge that samples the expiring `tick_in`, so latency is 1 cycle.
- `irq_out` falls the cycle after the edge sampling `irq_ack_in`.
- `play_out` follows the start/stop edge by 1 cycle.
- `tick_count_out` equals `cnt_r`: loaded value visible 1 cycle after start.
- Back-to-back `tick_in` every cycle is supported. With `period_r = 1`, every tick is an expiry.
- Reset mid-operation: all state cleared on the next edge, any pending request dropped.

## Configuration
- `AUDIOPORT_IRQ_OVERRUN_EN`:
  - Defined: `ovr_r` and its set/clear logic are present as described above.
  - Not defined: `overrun_out` is tied to 0 and no overrun register is synthesized. All other behaviour is identical.

## Test plan
- Reset, start with period=4, apply 4 ticks on consecutive cycles: `irq_out` is 1 the cycle after the 4th tick, `tick_count_out` reads 4,3,2,1,4, `play_out` = 1.
- `irq_out` high, pulse `irq_ack_in`: `irq_out` = 0 next cycle, state RUN. Then 4 more ticks raise `irq_out` again and `overrun_out` stays 0.
- Period=2, no ack, 4 ticks: `irq_out` = 1 after tick 2 and `overrun_out` = 1 after tick 4 (with `AUDIOPORT_IRQ_OVERRUN_EN` defined). Without the macro, `overrun_out` stays 0.
- Period=3 with `irq_out` pending, ack in the same cycle as the expiring 3rd tick: `irq_out` stays 1, `overrun_out` = 0.
- `start_in` and `stop_in` together while running: `play_out` = 0 next cycle. `start_in` with `irq_period_in` = 0 from IDLE: `play_out` stays 0.
- Assert `rst` mid-block with `irq_out` = 1 and `overrun_out` = 1: next cycle all outputs = 0, and subsequent `tick_in` is ignored.
